// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if: hazard/handshake inputs and stage enable/flush outputs of pipeline_ctrl_unit
interface pipeline_ctrl_if;
  logic [4:0] id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i;
  logic id_uses_rs1_i, id_uses_rs2_i, ex_MemRead_i, ex_redirect_i, mem_req_i, mem_ready_i;
  logic pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o, ex_mem_en_o, mem_wb_en_o;
  logic mem_timeout_o;
  logic [1:0] state_o;
  logic [31:0] stall_cycles_o, flush_count_o;
  modport master (
    output id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_MemRead_i, ex_redirect_i, mem_req_i, mem_ready_i,
    input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o, ex_mem_en_o,
           mem_wb_en_o, mem_timeout_o, state_o, stall_cycles_o, flush_count_o
  );
  modport slave (
    input  id_rs1_addr_i, id_rs2_addr_i, ex_rd_addr_i, id_uses_rs1_i, id_uses_rs2_i,
           ex_MemRead_i, ex_redirect_i, mem_req_i, mem_ready_i,
    output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o, ex_mem_en_o,
           mem_wb_en_o, mem_timeout_o, state_o, stall_cycles_o, flush_count_o
  );
endinterface

// File: rtl/pipeline_ctrl_unit.sv
// pipeline_ctrl_unit: 5-stage pipeline sequencer (stall/flush/timeout); PIPE_CTRL_PERF_CNT_EN adds perf counters
module pipeline_ctrl_unit #(
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic rst_n,
  pipeline_ctrl_if.slave p
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LAST = W'(MEM_TIMEOUT - 1);
  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, HALT = 2'd2} state_t;
  state_t state, state_n;
  logic [W-1:0] wait_cnt, wait_cnt_n;
  logic freeze, load_use, halt, active, timeout;
  always_comb begin
    freeze = p.mem_req_i & ~p.mem_ready_i;
    load_use = p.ex_MemRead_i & (p.ex_rd_addr_i != 5'd0) &
               ((p.id_uses_rs1_i & (p.id_rs1_addr_i == p.ex_rd_addr_i)) |
                (p.id_uses_rs2_i & (p.id_rs2_addr_i == p.ex_rd_addr_i)));
    halt = !(state == RUN || state == MEM_WAIT);
    active = !halt && !freeze;
    p.pc_en_o = active && (p.ex_redirect_i || !load_use);
    p.if_id_en_o = p.pc_en_o;
    p.if_id_flush_o = active && p.ex_redirect_i;
    p.id_ex_en_o = active;
    p.id_ex_flush_o = active && (p.ex_redirect_i || load_use);
    p.ex_mem_en_o = active;
    p.mem_wb_en_o = active;
  end
  always_comb begin
    state_n = HALT;
    wait_cnt_n = wait_cnt;
    case (state)
      RUN: begin
        state_n = freeze ? (MEM_TIMEOUT == 1 ? HALT : MEM_WAIT) : RUN;
        wait_cnt_n = freeze ? W'(1) : '0;
      end
      MEM_WAIT: begin
        state_n = !freeze ? RUN : (wait_cnt == LAST ? HALT : MEM_WAIT);
        wait_cnt_n = freeze ? wait_cnt + 1'b1 : '0;
      end
      default: state_n = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= RUN;
      wait_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      wait_cnt <= wait_cnt_n;
      timeout <= timeout | (state_n == HALT);
    end
  assign p.state_o = state;
  assign p.mem_timeout_o = timeout;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(!p.pc_en_o && !halt);
      flush_cnt <= flush_cnt + 32'(p.if_id_flush_o);
    end
  assign p.stall_cycles_o = stall_cnt;
  assign p.flush_count_o = flush_cnt;
`else
  assign p.stall_cycles_o = '0;
  assign p.flush_count_o = '0;
`endif
endmodule

// File: doc/pipeline_ctrl_unit.md
# pipeline_ctrl_unit

Pipeline sequencer for the 5-stage core. It decides every cycle which pipeline registers advance, hold or flush. It takes register-use information from ID, load/redirect information from EX and the data-memory handshake from MEM. It drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB enables and flushes, and halts the core on a data-memory timeout.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum consecutive data-memory wait cycles before halt; legal range 1..65535.

Ports:
- clk  in  1  core clock; all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs1_addr_i  in  5  rs1 field of instruction in ID
- id_rs2_addr_i  in  5  rs2 field of instruction in ID
- id_uses_rs1_i  in  1  ID instruction reads rs1
- id_uses_rs2_i  in  1  ID instruction reads rs2
- ex_rd_addr_i  in  5  rd of instruction in EX; 0 means no register write (ID zeroes rd when RegWrite=0)
- ex_MemRead_i  in  1  EX instruction is a load
- ex_redirect_i  in  1  EX resolved a taken branch or jump this cycle
- mem_req_i  in  1  MEM stage has an active data-memory access
- mem_ready_i  in  1  data memory completes the access this cycle
- pc_en_o  out  1  PC register update enable
- if_id_en_o / if_id_flush_o  out  1 each  IF/ID hold and bubble control
- id_ex_en_o / id_ex_flush_o  out  1 each  ID/EX hold and bubble control
- ex_mem_en_o  out  1  EX/MEM update enable
- mem_wb_en_o  out  1  MEM/WB update enable
- mem_timeout_o  out  1  sticky timeout error, registered
- state_o  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 HALT
- stall_cycles_o  out  32  performance counter (see Configuration)
- flush_count_o  out  32  performance counter (see Configuration)

## Operation
Definitions, all combinational:
- freeze = mem_req_i & ~mem_ready_i
- load_use = ex_MemRead_i & (ex_rd_addr_i != 0) & ((id_uses_rs1_i & id_rs1_addr_i == ex_rd_addr_i) | (id_uses_rs2_i & id_rs2_addr_i == ex_rd_addr_i))

Enable and flush outputs are combinational from the state and current inputs. Priority is freeze > redirect > load_use > normal.
- HALT (any inputs): all enables 0, all flushes 0.
- freeze (RUN or MEM_WAIT): all enables 0, all flushes 0. ex_redirect_i and load_use are ignored; EX is held, so they are re-evaluated on the release cycle.
- ex_redirect_i: all enables 1, if_id_flush_o=1, id_ex_flush_o=1. The PC loads the target; a concurrent load_use is discarded.
- load_use: pc_en_o=0, if_id_en_o=0, id_ex_en_o=1, id_ex_flush_o=1 (bubble). ex_mem_en_o and mem_wb_en_o are 1.
- normal: all enables 1, all flushes 0.
- Flush overrides enable in the pipeline registers. A flush is only asserted together with its enable at 1.

FSM, with wait_cnt of width clog2(MEM_TIMEOUT+1):
- RUN: on freeze, wait_cnt←1. Next state is HALT if MEM_TIMEOUT==1, else MEM_WAIT. Without freeze, wait_cnt←0 and the FSM stays in RUN.
- MEM_WAIT: freeze with wait_cnt==MEM_TIMEOUT-1 goes to HALT. Freeze otherwise increments wait_cnt. No freeze (release cycle, normal priority evaluation) clears wait_cnt and goes to RUN.
- HALT: absorbing until rst_n. mem_timeout_o←1 on entry.
- Invalid state encoding 3 is treated as HALT.

## Timing
- Reset (rst_n=0, asynchronous): state RUN, wait_cnt 0, mem_timeout_o 0, counters 0. Combinational outputs follow the RUN rules immediately.
- Zero-cycle latency from inputs to enables and flushes. These outputs are sampled by the pipeline registers on the same edge.
- Load-use costs exactly 1 bubble. On the next cycle the load is in MEM and load_use deasserts naturally.
- Redirect costs 2 flushed slots (IF/ID, ID/EX) in 1 cycle.
- mem_ready_i in the first request cycle means no freeze and no state change.
- Timeout: a continuous freeze lasting MEM_TIMEOUT cycles makes state_o=2 and mem_timeout_o=1 on the following edge.
- Reset asserted mid-MEM_WAIT or in HALT returns to RUN at once. mem_timeout_o clears.

## Configuration
- PIPE_CTRL_PERF_CNT_EN defined:
  - stall_cycles_o increments on every cycle with pc_en_o=0 and state≠HALT.
  - flush_count_o increments on every cycle with ex_redirect_i accepted (if_id_flush_o=1).
  - Both counters wrap at 2^32 and reset to 0.
- PIPE_CTRL_PERF_CNT_EN not defined: both outputs are tied to 0 and no counter registers are built. All other behaviour is identical.

## Test plan
- Load-use: ex_MemRead_i=1, ex_rd_addr_i=5, id_rs2_addr_i=5, id_uses_rs2_i=1 -> pc_en_o=0, if_id_en_o=0, id_ex_flush_o=1 for 1 cycle. The same stimulus with ex_rd_addr_i=0 gives no stall.
- Redirect + load_use in the same cycle -> if_id_flush_o=1, id_ex_flush_o=1, pc_en_o=1, no stall. flush_count_o goes 0→1 when PIPE_CTRL_PERF_CNT_EN is defined.
- mem_req_i=1, mem_ready_i=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, state_o=1 on cycles 2–3, state_o=0 after release. stall_cycles_o=3.
- MEM_TIMEOUT=4, mem_ready_i held 0 -> freeze for cycles 0–3, then state_o=2 and mem_timeout_o=1. A later mem_ready_i=1 keeps all enables 0.
- Redirect during freeze -> ignored while frozen. It is applied (both flushes) on the release cycle.
- rst_n pulsed low asynchronously while in HALT -> immediate state_o=0, mem_timeout_o=0, counters 0, normal enables.
